// File: rtl/rtt_stats_pkg.sv
// Shared definitions for the RTT statistics collector: FSM states, IOQ
// header field positions, report control codes and cnt_upd bit indices.
package rtt_stats_pkg;

  typedef enum logic [3:0] {
    ST_HDR,
    ST_SKIP_RX,
    ST_SKIP_PAD,
    ST_THRU,
    ST_PROBE_RX,
    ST_PROBE_TAIL,
    ST_COMMIT,
    ST_REP_HDR,
    ST_REP_DATA
  } state_e;

  // IOQ module header layout (16-bit fields)
  localparam int IOQ_FIELD_W      = 16;
  localparam int IOQ_BYTE_LEN_POS = 0;
  localparam int IOQ_SRC_PORT_POS = 16;
  localparam int IOQ_WORD_LEN_POS = 32;
  localparam int IOQ_DST_PORT_POS = 48;

  // Control codes used on emitted words
  localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hff;
  localparam logic [7:0] REP_LAST_CTRL      = 8'h80;

  // Two timestamp words are stripped from forwarded packets
  localparam int STRIP_WORDS = 2;
  localparam int STRIP_BYTES = 16;

  // Each timestamp occupies one 32-bit half of a report data word
  localparam int TS_SLOT_W = 32;

  // cnt_upd pulse positions
  localparam int CNT_FWD    = 0;
  localparam int CNT_SAMPLE = 1;
  localparam int CNT_REPORT = 2;
  localparam int CNT_DROP   = 3;

endpackage

// File: rtl/rtt_sample_fifo.sv
// Synchronous first-word-fallthrough FIFO with full/empty/count.
// Used for the per-channel timestamp sample store and the input buffer.
module rtt_sample_fifo #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      din,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_BITS:0]   count
);

  localparam int DEPTH = 2 ** DEPTH_BITS;
  localparam int CNT_W = DEPTH_BITS + 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_wr, do_rd;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; writes when full and reads when empty are ignored
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers; reset empties the FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array
  // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/rtt_stats_collector.sv
// RTT statistics collector. Forwarded packets lose their two timestamp
// words; probe packets to CPU queues are consumed and their rx/tx stamps
// stored per channel, then reported to that channel's CPU queue.
// Optional feature: define STATS_FLUSH_TIMEOUT_EN to flush partial sample
// sets after FLUSH_CYCLES idle cycles.
module rtt_stats_collector
  import rtt_stats_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int NUM_CH          = 4,
  parameter int TS_WIDTH        = 32,
  parameter int FIFO_DEPTH_BITS = 4,
  parameter int REPORT_THRESH   = 8,
  parameter int FLUSH_CYCLES    = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_ctrl,
  input  logic                    in_wr,
  output logic                    in_rdy,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [DATA_WIDTH/8-1:0] out_ctrl,
  output logic                    out_wr,
  input  logic                    out_rdy,
  output logic [3:0]              cnt_upd
);

  localparam int CTRL_WIDTH = DATA_WIDTH / 8;
  localparam int IN_W       = DATA_WIDTH + CTRL_WIDTH;
  localparam int SAMP_W     = 2 * TS_WIDTH;
  localparam int CNT_W      = FIFO_DEPTH_BITS + 1;
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // ---------------- input buffer ----------------
  logic                  in_rd, in_full, in_empty;
  logic [2:0]            in_count;
  logic [IN_W-1:0]       in_head;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;

  rtt_sample_fifo #(.WIDTH(IN_W), .DEPTH_BITS(2)) u_in_fifo (
    .clk(clk), .reset(reset),
    .wr_en(in_wr), .din({in_data, in_ctrl}),
    .rd_en(in_rd), .dout(in_head),
    .full(in_full), .empty(in_empty), .count(in_count)
  );

  assign head_data = in_head[IN_W-1 -: DATA_WIDTH];
  assign head_ctrl = in_head[CTRL_WIDTH-1:0];
  assign in_rdy    = !(in_full || in_count == 3'd3);

  // ---------------- per-channel sample stores ----------------
  logic [NUM_CH-1:0] push_en, pop_en, samp_full, samp_empty;
  logic [SAMP_W-1:0] samp_dout  [NUM_CH];
  logic [CNT_W-1:0]  samp_count [NUM_CH];
  logic [TS_WIDTH-1:0] rx_ts_q, rx_ts_d, tx_ts_q, tx_ts_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rtt_sample_fifo #(.WIDTH(SAMP_W), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_samp (
      .clk(clk), .reset(reset),
      .wr_en(push_en[g]), .din({rx_ts_q, tx_ts_q}),
      .rd_en(pop_en[g]), .dout(samp_dout[g]),
      .full(samp_full[g]), .empty(samp_empty[g]), .count(samp_count[g])
    );
  end

  // ---------------- FSM registers ----------------
  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  rep_left_q, rep_left_d;
  logic [3:0]        cnt_upd_q, cnt_upd_d;

  logic              probe_hit, rep_pend, report_go;
  logic [CH_W-1:0]   probe_ch, pend_ch;
  logic [CNT_W:0]    commit_cnt;
  logic [DATA_WIDTH-1:0] fwd_hdr, rep_hdr, rep_word;

  // Channel priority decode: lowest index wins for probes and pending reports
  always_comb begin
    probe_hit = 1'b0;
    probe_ch  = '0;
    rep_pend  = 1'b0;
    pend_ch   = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (head_data[IOQ_DST_PORT_POS + 2 * c + 1]) begin
        probe_hit = 1'b1;
        probe_ch  = CH_W'(c);
      end
      if (samp_count[c] >= CNT_W'(REPORT_THRESH)) begin
        rep_pend = 1'b1;
        pend_ch  = CH_W'(c);
      end
    end
  end

`ifdef STATS_FLUSH_TIMEOUT_EN
  localparam int IDLE_W = $clog2(FLUSH_CYCLES + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              flush_go;
  logic [CH_W-1:0]   flush_ch;

  // Lowest non-empty channel is the flush candidate
  always_comb begin
    flush_ch = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (!samp_empty[c]) flush_ch = CH_W'(c);
    end
  end

  assign flush_go = (idle_q == IDLE_W'(FLUSH_CYCLES)) && !(&samp_empty);

  // Idle cycles in HDR with nothing buffered; any input word or finished report restarts it
  always_comb begin
    idle_d = idle_q;
    if (in_wr || cnt_upd_d[CNT_REPORT])
      idle_d = '0;
    else if (state_q == ST_HDR && in_empty && idle_q != IDLE_W'(FLUSH_CYCLES))
      idle_d = idle_q + IDLE_W'(1);
  end

  // Idle counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  logic            flush_go;
  logic [CH_W-1:0] flush_ch;
  assign flush_go = 1'b0;
  assign flush_ch = '0;
`endif

  assign report_go  = rep_pend || flush_go;
  assign commit_cnt = (CNT_W + 1)'(samp_count[ch_q]) + (CNT_W + 1)'(!samp_full[ch_q]);

  // Header rewrites and report word formatting
  always_comb begin
    fwd_hdr = head_data;
    fwd_hdr[IOQ_BYTE_LEN_POS +: IOQ_FIELD_W] =
      head_data[IOQ_BYTE_LEN_POS +: IOQ_FIELD_W] - IOQ_FIELD_W'(STRIP_BYTES);
    fwd_hdr[IOQ_WORD_LEN_POS +: IOQ_FIELD_W] =
      head_data[IOQ_WORD_LEN_POS +: IOQ_FIELD_W] - IOQ_FIELD_W'(STRIP_WORDS);
    rep_hdr = '0;
    rep_hdr[IOQ_DST_PORT_POS +: IOQ_FIELD_W] = IOQ_FIELD_W'(1) << (2 * ch_q + 1);
    rep_hdr[IOQ_WORD_LEN_POS +: IOQ_FIELD_W] = IOQ_FIELD_W'(samp_count[ch_q]);
    rep_hdr[IOQ_BYTE_LEN_POS +: IOQ_FIELD_W] = IOQ_FIELD_W'({samp_count[ch_q], 3'b000});
    rep_word = '0;
    rep_word[TS_SLOT_W +: TS_WIDTH] = samp_dout[ch_q][SAMP_W-1 -: TS_WIDTH];
    rep_word[0 +: TS_WIDTH]         = samp_dout[ch_q][TS_WIDTH-1:0];
  end

  // FSM state register plus latched channel, timestamps and report progress
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q    <= ST_HDR;
      ch_q       <= '0;
      rx_ts_q    <= '0;
      tx_ts_q    <= '0;
      rep_left_q <= '0;
      cnt_upd_q  <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      rx_ts_q    <= rx_ts_d;
      tx_ts_q    <= tx_ts_d;
      rep_left_q <= rep_left_d;
      cnt_upd_q  <= cnt_upd_d;
    end
  end

  // Next-state logic; pending reports take precedence over the next input header
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    rx_ts_d    = rx_ts_q;
    tx_ts_d    = tx_ts_q;
    rep_left_d = rep_left_q;
    case (state_q)
      ST_HDR: begin
        if (rep_pend) begin
          state_d = ST_REP_HDR;
          ch_d    = pend_ch;
        end else if (flush_go) begin
          state_d = ST_REP_HDR;
          ch_d    = flush_ch;
        end else if (in_rd) begin
          if (probe_hit) begin
            state_d = ST_PROBE_RX;
            ch_d    = probe_ch;
          end else begin
            state_d = ST_SKIP_RX;
          end
        end
      end
      ST_SKIP_RX:  if (in_rd) state_d = ST_SKIP_PAD;
      ST_SKIP_PAD: if (in_rd) state_d = ST_THRU;
      ST_THRU:     if (in_rd && head_ctrl != '0) state_d = ST_HDR;
      ST_PROBE_RX: begin
        if (in_rd) begin
          rx_ts_d = head_data[TS_WIDTH-1:0];
          state_d = (head_ctrl != '0) ? ST_HDR : ST_PROBE_TAIL;
        end
      end
      ST_PROBE_TAIL: begin
        if (in_rd && head_ctrl != '0) begin
          tx_ts_d = head_data[TS_WIDTH-1:0];
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = (commit_cnt >= (CNT_W + 1)'(REPORT_THRESH)) ? ST_REP_HDR : ST_HDR;
      end
      ST_REP_HDR: begin
        if (out_rdy) begin
          rep_left_d = samp_count[ch_q];
          state_d    = ST_REP_DATA;
        end
      end
      ST_REP_DATA: begin
        if (out_rdy) begin
          rep_left_d = rep_left_q - CNT_W'(1);
          if (rep_left_q == CNT_W'(1)) state_d = ST_HDR;
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

  // Outputs and handshakes decoded from the current state
  always_comb begin
    out_wr    = 1'b0;
    out_data  = '0;
    out_ctrl  = '0;
    in_rd     = 1'b0;
    push_en   = '0;
    pop_en    = '0;
    cnt_upd_d = '0;
    case (state_q)
      ST_HDR: begin
        if (!report_go && !in_empty) begin
          if (probe_hit) begin
            in_rd = 1'b1;
          end else begin
            out_wr   = 1'b1;
            out_data = fwd_hdr;
            out_ctrl = head_ctrl;
            if (out_rdy) begin
              in_rd              = 1'b1;
              cnt_upd_d[CNT_FWD] = 1'b1;
            end
          end
        end
      end
      ST_SKIP_RX, ST_SKIP_PAD, ST_PROBE_TAIL: in_rd = !in_empty;
      ST_PROBE_RX: begin
        in_rd = !in_empty;
        if (!in_empty && head_ctrl != '0) cnt_upd_d[CNT_DROP] = 1'b1;
      end
      ST_THRU: begin
        if (!in_empty) begin
          out_wr   = 1'b1;
          out_data = head_data;
          out_ctrl = head_ctrl;
          in_rd    = out_rdy;
        end
      end
      ST_COMMIT: begin
        if (!samp_full[ch_q]) begin
          push_en[ch_q]         = 1'b1;
          cnt_upd_d[CNT_SAMPLE] = 1'b1;
        end else begin
          cnt_upd_d[CNT_DROP] = 1'b1;
        end
      end
      ST_REP_HDR: begin
        out_wr   = 1'b1;
        out_data = rep_hdr;
        out_ctrl = CTRL_WIDTH'(IO_QUEUE_STAGE_NUM);
      end
      ST_REP_DATA: begin
        out_wr   = 1'b1;
        out_data = rep_word;
        out_ctrl = (rep_left_q == CNT_W'(1)) ? CTRL_WIDTH'(REP_LAST_CTRL) : '0;
        if (out_rdy) begin
          pop_en[ch_q] = !samp_empty[ch_q];
          if (rep_left_q == CNT_W'(1)) cnt_upd_d[CNT_REPORT] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign cnt_upd = cnt_upd_q;

endmodule
